// File: rtl/i2c_slave.sv
// i2c_slave: oversampled I2C target with 7-bit addressing, byte write/read and per-byte ACK/NACK.
// Optional I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample stability filter on scl/sda after the synchronizers.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addressed,
  output logic       busy,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_RX        = 4'd3,
    ST_RX_ACK    = 4'd4,
    ST_TX        = 4'd5,
    ST_TX_ACK    = 4'd6,
    ST_WAIT_STOP = 4'd7
  } state_e;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_s, sda_s;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of block order.
  // Synchronizers reset to 1 so an idle bus produces no spurious edges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic       scl_filt_q, sda_filt_q;
  logic [1:0] scl_cnt_q, sda_cnt_q;

  // A new level is adopted on its third consecutive sample; shorter pulses vanish.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
      scl_cnt_q  <= 2'd0;
      sda_cnt_q  <= 2'd0;
    end else begin
      if (scl_sync_q[1] == scl_filt_q) begin
        scl_cnt_q <= 2'd0;
      end else if (scl_cnt_q == 2'd2) begin
        scl_filt_q <= scl_sync_q[1];
        scl_cnt_q  <= 2'd0;
      end else begin
        scl_cnt_q <= scl_cnt_q + 2'd1;
      end
      if (sda_sync_q[1] == sda_filt_q) begin
        sda_cnt_q <= 2'd0;
      end else if (sda_cnt_q == 2'd2) begin
        sda_filt_q <= sda_sync_q[1];
        sda_cnt_q  <= 2'd0;
      end else begin
        sda_cnt_q <= sda_cnt_q + 2'd1;
      end
    end
  end

  assign scl_s = scl_filt_q;
  assign sda_s = sda_filt_q;
`else
  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];
`endif

  logic scl_prev_q, sda_prev_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_rise  =  scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s &  scl_prev_q;
  assign start_det =  scl_s &  scl_prev_q &  sda_prev_q & ~sda_s;
  assign stop_det  =  scl_s &  scl_prev_q & ~sda_prev_q &  sda_s;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       byte_done_q, byte_done_d;
  logic       rw_q, rw_d;
  logic       nack_q, nack_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       addressed_q, addressed_d;
  logic       busy_q, busy_d;

  // NOTE: every combinational output gets a default before the case so no
  // path through the block leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_done_d = byte_done_q;
    rw_d        = rw_q;
    nack_d      = nack_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    addressed_d = addressed_q;
    busy_d      = busy_q;

    if (start_det) begin
      state_d     = ST_ADDR;
      busy_d      = 1'b1;
      addressed_d = 1'b0;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
    end else if (stop_det && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      busy_d      = 1'b0;
      addressed_d = 1'b0;
      sda_oe_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_RX: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_done_d = 1'b1;
              if (state_q == ST_ADDR) begin
                rw_d = sda_s;
                // General call (address 0) is never claimed.
                if ((shift_q[6:0] != SLAVE_ADDR) || (shift_q[6:0] == 7'd0)) begin
                  state_d = ST_WAIT_STOP;
                end
              end else begin
                rx_data_d  = {shift_q[6:0], sda_s};
                rx_valid_d = 1'b1;
              end
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b1;
            if (state_q == ST_ADDR) begin
              state_d     = ST_ADDR_ACK;
              addressed_d = 1'b1;
            end else begin
              state_d = ST_RX_ACK;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            if (rw_q) begin
              shift_d  = tx_data;
              sda_oe_d = ~tx_data[7];
              state_d  = ST_TX;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_RX;
            end
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = ST_RX;
          end
        end
        ST_TX: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_done_d = 1'b1;
            end
          end else if (scl_fall) begin
            if (byte_done_q) begin
              byte_done_d = 1'b0;
              sda_oe_d    = 1'b0;
              state_d     = ST_TX_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            nack_d = sda_s;
          end else if (scl_fall) begin
            if (nack_q) begin
              sda_oe_d = 1'b0;
              state_d  = ST_WAIT_STOP;
            end else begin
              shift_d   = tx_data;
              sda_oe_d  = ~tx_data[7];
              bit_cnt_d = 3'd0;
              state_d   = ST_TX;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      byte_done_q <= 1'b0;
      rw_q        <= 1'b0;
      nack_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      addressed_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_done_q <= byte_done_d;
      rw_q        <= rw_d;
      nack_q      <= nack_d;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      addressed_q <= addressed_d;
      busy_q      <= busy_d;
    end
  end

  // Open-drain: only ever pull low or release; the async reset releases it at once.
  assign sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign addressed = addressed_q;
  assign busy      = busy_q;
  assign state     = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: directed I2C master sequence against i2c_slave with rx/tx byte scoreboards.
module tb_i2c_slave;

  localparam int H = 10;
  localparam int Q = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       addressed;
  logic       busy;
  logic [3:0] state;
  wire        sda_bus;

  pullup (sda_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clock     (clock),
    .reset     (reset),
    .scl       (m_scl),
    .sda       (sda_bus),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .addressed (addressed),
    .busy      (busy),
    .state     (state)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         failures = 0;
  int         rx_pulses = 0;
  logic       rx_valid_prev = 1'b0;
  logic       slave_drove = 1'b0;
  logic       watch_busy = 1'b0;
  logic       busy_dropped = 1'b0;
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_tx_q[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard side for writes, plus bus-level watchers.
  always @(negedge clock) begin
    if (rx_valid_prev) check("rx_valid_one_cycle", {7'd0, rx_valid}, 8'd0);
    if (rx_valid === 1'b1) begin
      rx_pulses++;
      if (exp_rx_q.size() == 0) check("rx_unexpected", rx_data, 8'hxx);
      else check("rx_data", rx_data, exp_rx_q.pop_front());
    end
    rx_valid_prev = (rx_valid === 1'b1);
    if (sda_bus === 1'b0 && !m_sda_low) slave_drove = 1'b1;
    if (watch_busy && busy !== 1'b1) busy_dropped = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One scl period starting and ending with scl low; returns sda sampled mid-high.
  task automatic bit_clock(input logic b, output logic sampled);
    wait_cyc(Q);
    m_sda_low = ~b;
    wait_cyc(Q);
    m_scl = 1'b1;
    wait_cyc(Q);
    sampled = sda_bus;
    wait_cyc(Q);
    m_scl = 1'b0;
  endtask

  task automatic i2c_start();
    wait_cyc(Q);
    m_sda_low = 1'b0;
    wait_cyc(Q);
    m_scl = 1'b1;
    wait_cyc(H);
    m_sda_low = 1'b1;
    wait_cyc(H);
    m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_cyc(Q);
    m_sda_low = 1'b1;
    wait_cyc(Q);
    m_scl = 1'b1;
    wait_cyc(H);
    m_sda_low = 1'b0;
    wait_cyc(H);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_clock(b[i], s);
    bit_clock(1'b1, ack);
  endtask

  task automatic read_byte(input logic master_nack, input logic [7:0] next_tx, output logic [7:0] data);
    logic s;
    data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_clock(1'b1, s);
      data = {data[6:0], s};
    end
    tx_data = next_tx;
    bit_clock(master_nack, s);
  endtask

  initial begin
    logic       ack;
    logic [7:0] data;
    logic       s;
    int         base_pulses;
    logic       busy_seen;
    logic       addr_seen;

    wait_cyc(4);
    check("reset_state", {4'd0, state}, 8'd0);
    check("reset_busy", {7'd0, busy}, 8'd0);
    check("reset_addressed", {7'd0, addressed}, 8'd0);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_sda_released", {7'd0, sda_bus}, 8'd1);
    reset = 1'b0;
    wait_cyc(10);

    // Write to our address.
    i2c_start();
    check("w_busy", {7'd0, busy}, 8'd1);
    write_byte(8'hA0, ack);
    check("w_addr_ack", {7'd0, ack}, 8'd0);
    check("w_addressed", {7'd0, addressed}, 8'd1);
    exp_rx_q.push_back(8'hA5);
    write_byte(8'hA5, ack);
    check("w_data_ack", {7'd0, ack}, 8'd0);
    check("w_rx_pulses", rx_pulses[7:0], 8'd1);
    check("w_addressed_hold", {7'd0, addressed}, 8'd1);
    i2c_stop();
    wait_cyc(10);
    check("w_addressed_after_stop", {7'd0, addressed}, 8'd0);
    check("w_busy_after_stop", {7'd0, busy}, 8'd0);
    check("w_state_idle", {4'd0, state}, 8'd0);

    // Address mismatch.
    base_pulses = rx_pulses;
    slave_drove = 1'b0;
    i2c_start();
    write_byte(8'hA2, ack);
    check("mm_addr_nack", {7'd0, ack}, 8'd1);
    check("mm_state_wait", {4'd0, state}, 8'd7);
    write_byte(8'h55, ack);
    check("mm_state_wait2", {4'd0, state}, 8'd7);
    check("mm_addressed", {7'd0, addressed}, 8'd0);
    i2c_stop();
    wait_cyc(10);
    check("mm_state_idle", {4'd0, state}, 8'd0);
    check("mm_sda_never_driven", {7'd0, slave_drove}, 8'd0);
    check("mm_no_rx_pulse", rx_pulses[7:0], base_pulses[7:0]);

    // Two-byte read: ACK then NACK.
    tx_data = 8'h3C;
    exp_tx_q.push_back(8'h3C);
    i2c_start();
    write_byte(8'hA1, ack);
    check("rd_addr_ack", {7'd0, ack}, 8'd0);
    wait_cyc(8);
    check("rd_state_tx", {4'd0, state}, 8'd5);
    exp_tx_q.push_back(8'hC3);
    read_byte(1'b0, 8'hC3, data);
    check("rd_byte1", data, exp_tx_q.pop_front());
    read_byte(1'b1, 8'h00, data);
    check("rd_byte2", data, exp_tx_q.pop_front());
    wait_cyc(8);
    check("rd_sda_released", {7'd0, sda_bus}, 8'd1);
    check("rd_state_wait_stop", {4'd0, state}, 8'd7);
    i2c_stop();
    wait_cyc(10);
    check("rd_state_idle", {4'd0, state}, 8'd0);

    // Repeated START: write then read without STOP.
    i2c_start();
    watch_busy = 1'b1;
    busy_dropped = 1'b0;
    write_byte(8'hA0, ack);
    check("rs_addr1_ack", {7'd0, ack}, 8'd0);
    exp_rx_q.push_back(8'h11);
    write_byte(8'h11, ack);
    check("rs_data_ack", {7'd0, ack}, 8'd0);
    check("rs_rx_data", rx_data, 8'h11);
    tx_data = 8'h5A;
    exp_tx_q.push_back(8'h5A);
    i2c_start();
    check("rs_addressed_cleared", {7'd0, addressed}, 8'd0);
    write_byte(8'hA1, ack);
    check("rs_addr2_ack", {7'd0, ack}, 8'd0);
    wait_cyc(8);
    check("rs_state_tx", {4'd0, state}, 8'd5);
    read_byte(1'b1, 8'h00, data);
    check("rs_read_byte", data, exp_tx_q.pop_front());
    watch_busy = 1'b0;
    check("rs_busy_held", {7'd0, busy_dropped}, 8'd0);
    i2c_stop();
    wait_cyc(10);

    // Reset while the slave holds the data ACK low.
    i2c_start();
    write_byte(8'hA0, ack);
    exp_rx_q.push_back(8'h77);
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] v;
      v = 8'h77;
      bit_clock(v[i], s);
    end
    wait_cyc(8);
    check("ra_state_rx_ack", {4'd0, state}, 8'd4);
    check("ra_sda_low", {7'd0, sda_bus}, 8'd0);
    reset = 1'b1;
    #1;
    check("ra_sda_released", {7'd0, sda_bus}, 8'd1);
    check("ra_state", {4'd0, state}, 8'd0);
    check("ra_busy", {7'd0, busy}, 8'd0);
    check("ra_addressed", {7'd0, addressed}, 8'd0);
    check("ra_rx_data", rx_data, 8'h00);
    check("ra_rx_valid", {7'd0, rx_valid}, 8'd0);
    m_scl = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(10);
    i2c_start();
    write_byte(8'hA0, ack);
    check("ra_post_addr_ack", {7'd0, ack}, 8'd0);
    exp_rx_q.push_back(8'h42);
    write_byte(8'h42, ack);
    check("ra_post_data_ack", {7'd0, ack}, 8'd0);
    i2c_stop();
    wait_cyc(10);
    check("ra_post_rx_data", rx_data, 8'h42);
    check("ra_post_idle", {4'd0, state}, 8'd0);

    // Two-cycle sda low pulse while scl is high in IDLE.
    busy_seen = 1'b0;
    addr_seen = 1'b0;
    m_sda_low = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (i == 1) m_sda_low = 1'b0;
      if (busy === 1'b1) busy_seen = 1'b1;
      if (state === 4'd1) addr_seen = 1'b1;
    end
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    check("gl_busy_seen", {7'd0, busy_seen}, 8'd0);
    check("gl_addr_seen", {7'd0, addr_seen}, 8'd0);
`else
    check("gl_busy_seen", {7'd0, busy_seen}, 8'd1);
    check("gl_addr_seen", {7'd0, addr_seen}, 8'd1);
`endif
    wait_cyc(10);
    check("gl_state_idle", {4'd0, state}, 8'd0);
    check("gl_busy_final", {7'd0, busy}, 8'd0);

    check("rx_queue_drained", exp_rx_q.size() > 0 ? 8'd1 : 8'd0, 8'd0);
    check("tx_queue_drained", exp_tx_q.size() > 0 ? 8'd1 : 8'd0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- Responder end of the team's I2C link: the target device that the master block addresses over scl/sda.
- Oversamples scl/sda on the system clock and detects START, repeated START and STOP.
- Receives the 7-bit address plus R/W bit, and ACKs only its own address.
- Then either receives bytes (write) or transmits bytes (read), with full per-byte ACK/NACK handling.

Parameters:
- SLAVE_ADDR, 7'h50, own 7-bit bus address compared against the received address.

Ports:
- clock  input  1  system clock; frequency at least 10x SCL.
- reset  input  1  asynchronous, active-high reset.
- scl  input  1  bus clock from the master.
- sda  inout  1  bus data; the block only drives 0 or releases to Z (open-drain).
- tx_data  input  8  byte to transmit on a read; sampled at each byte load.
- rx_data  output  8  last byte received on a write.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- addressed  output  1  high from our address ACK until STOP or repeated START.
- busy  output  1  high between START and STOP, whatever the address.
- state  output  4  current FSM state, for debug.

Behaviour:
- Reset (async, any state): sda=Z, rx_data=0, rx_valid=0, addressed=0, busy=0, state=IDLE. Reset mid-byte or mid-ACK releases sda immediately.
- Input conditioning: scl and sda each pass a 2-flop synchronizer. Edge detect uses the synchronized values. All events are seen 2 cycles after the pin changes.
- START: synced sda falls while synced scl=1. Valid from any state, including repeated START. Action: busy=1, addressed=0, bit counter=0, state=ADDR.
- STOP: synced sda rises while synced scl=1. Valid from any state except IDLE. Action: sda=Z, busy=0, addressed=0, state=IDLE.
- If START/STOP coincide with an scl edge event in the same cycle, START/STOP wins.
- Sampling and driving: data is sampled on the scl rising edge. The block changes sda only on the scl falling edge. sda is never changed while scl=1.
- Bit counter: 3 bits, counts scl rising edges within a byte, MSB first. Wraps 7->0 at the byte end.
- State encoding:
  - IDLE=0, ADDR=1, ADDR_ACK=2, RX=3, RX_ACK=4, TX=5, TX_ACK=6, WAIT_STOP=7.
- IDLE: waits for START only.
- ADDR: shifts 8 bits. After the 8th rising edge, compares bits[7:1] with SLAVE_ADDR.
  - Match: on the following scl fall, drive sda=0 and go to ADDR_ACK.
  - Mismatch: go to WAIT_STOP; sda stays Z.
- ADDR_ACK: addressed=1. On the next scl fall (end of the 9th clock):
  - R/W=0: release sda, go to RX.
  - R/W=1: latch tx_data into the shift register, drive its MSB, go to TX.
- RX: shifts 8 bits. On the 8th rising edge: rx_data<=shift register, rx_valid pulses for 1 cycle. On the next scl fall, drive sda=0 and go to RX_ACK.
- RX_ACK: on the next scl fall, release sda and return to RX. Multi-byte writes are unlimited.
- TX: drives the shift register MSB. Shifts left on each scl fall. After 8 bits, on the 8th fall, release sda and go to TX_ACK.
- TX_ACK: samples master sda on the scl rise.
  - ACK (0): on the scl fall, latch tx_data, drive its MSB, go to TX.
  - NACK (1): go to WAIT_STOP with sda=Z.
- WAIT_STOP: sda=Z; waits for STOP or repeated START.
- General call (address 0) is not ACKed. The block never stretches the clock.

Optional Feature:
- Macro: I2C_SLAVE_GLITCH_FILTER_EN.
- When defined: after the synchronizers, scl and sda each pass a stability filter. A new level is accepted only after 3 consecutive identical samples. Total input latency becomes 5 cycles. Pulses shorter than 3 clock cycles are suppressed entirely; no START/STOP or edge event is generated.
- When undefined: synchronizers only, 2-cycle latency. Every sampled transition counts.

Test Plan:
- Write to matching address, SLAVE_ADDR=0x50: START, 0xA0, 0xA5, STOP -> sda=0 during both 9th clocks; rx_data=0xA5; rx_valid high exactly 1 cycle; addressed=1 until STOP; state ends IDLE.
- Address mismatch: START, 0xA2, 0x55, STOP -> sda never driven; rx_valid never pulses; addressed=0; state=WAIT_STOP until STOP, then IDLE.
- Read, 2 bytes: START, 0xA1; tx_data=0x3C, then 0xC3 after the first byte; master ACKs byte 1 and NACKs byte 2 -> sda shows 00111100 then 11000011 during scl high; after the NACK, sda=Z and state=WAIT_STOP.
- Repeated START: write 0xA0, 0x11, then START without STOP, then 0xA1 read -> rx_data=0x11; new address ACKed; transfer continues in TX with busy held high throughout.
- Reset mid-ACK: assert reset while the slave holds sda=0 in RX_ACK -> sda=Z the same cycle; all outputs reach reset values; the next START/address is handled normally.
- Glitch filter, with I2C_SLAVE_GLITCH_FILTER_EN: 2-cycle sda low pulse while scl=1 in IDLE -> no START detected and busy stays 0. Without the macro, the same stimulus -> busy=1 and state=ADDR.
